// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: request/parameter inputs and counter-drive outputs of sweep_ctrl.
// master drives the sweep request, slave is the controller itself.
interface sweep_ctrl_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL_W = 16
);
   logic               start;
   logic               stop;
   logic [WIDTH-1:0]   incr_min;
   logic [WIDTH-1:0]   incr_max;
   logic [WIDTH-1:0]   step;
   logic [DWELL_W-1:0] dwell;
   logic               en;
   logic [WIDTH-1:0]   incr;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output start, stop, incr_min, incr_max, step, dwell,
      input  en, incr, busy, done, err
   );

   modport slave (
      input  start, stop, incr_min, incr_max, step, dwell,
      output en, incr, busy, done, err
   );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: ramps a phase increment from min up to max and back down, holding each
// value for a dwell period. Optional macro SWEEP_LOOP_EN: repeat the up/down pass
// until stop instead of ending after one pass.
module sweep_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL_W = 16
) (
   input logic         clk,
   input logic         rst,
   sweep_ctrl_if.slave bus
);
   typedef enum logic [1:0] {StIdle = 2'd0, StUp = 2'd1, StDown = 2'd2} state_e;

   localparam logic [DWELL_W-1:0] DwOne = DWELL_W'(1);

   state_e             state_q;
   logic [WIDTH-1:0]   incr_q;
   logic [WIDTH-1:0]   min_q;
   logic [WIDTH-1:0]   max_q;
   logic [WIDTH-1:0]   step_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] cnt_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic               armed_q;

   logic [DWELL_W-1:0] cnt_last;
   logic               expire;
   logic [WIDTH:0]     up_sum;
   logic [WIDTH:0]     dn_diff;
   logic               up_sat;
   logic               dn_clamp;
   logic               at_min;
   logic               bad_req;

   // Dwell expiry and the extended-width step arithmetic for both sweep directions.
   always_comb begin
      cnt_last = (dwell_q == '0) ? '0 : dwell_q - DwOne;  // dwell of 0 behaves as 1
      expire   = (cnt_q == cnt_last);
      up_sum   = {1'b0, incr_q} + {1'b0, step_q};
      dn_diff  = {1'b0, incr_q} - {1'b0, step_q};
      up_sat   = (up_sum >= {1'b0, max_q});
      dn_clamp = ($signed(dn_diff) <= $signed({1'b0, min_q}));
      at_min   = (incr_q == min_q);
      bad_req  = (bus.incr_min > bus.incr_max) || (bus.step == '0);
   end

   // Sweep FSM with registered outputs; armed_q blocks start on the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         incr_q  <= '0;
         min_q   <= '0;
         max_q   <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         armed_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (armed_q && bus.start && !bus.stop) begin
                  if (bad_req) begin
                     err_q <= 1'b1;
                  end else begin
                     min_q   <= bus.incr_min;
                     max_q   <= bus.incr_max;
                     step_q  <= bus.step;
                     dwell_q <= bus.dwell;
                     incr_q  <= bus.incr_min;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= StUp;
                  end
               end
            end
            StUp: begin
               if (bus.stop) begin
                  state_q <= StIdle;
                  incr_q  <= '0;
                  busy_q  <= 1'b0;
               end else if (expire) begin
                  cnt_q <= '0;
                  if (up_sat) begin
                     incr_q  <= max_q;
                     state_q <= StDown;
                  end else begin
                     incr_q <= up_sum[WIDTH-1:0];
                  end
               end else begin
                  cnt_q <= cnt_q + DwOne;
               end
            end
            StDown: begin
               if (bus.stop) begin
                  state_q <= StIdle;
                  incr_q  <= '0;
                  busy_q  <= 1'b0;
               end else if (expire) begin
                  cnt_q <= '0;
                  // min is held for a full dwell before the pass counts as complete
                  if (at_min) begin
                     done_q  <= 1'b1;
`ifdef SWEEP_LOOP_EN
                     state_q <= StUp;
`else
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
`endif
                  end else if (dn_clamp) begin
                     incr_q <= min_q;
                  end else begin
                     incr_q <= dn_diff[WIDTH-1:0];
                  end
               end else begin
                  cnt_q <= cnt_q + DwOne;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.en   = busy_q;
   assign bus.busy = busy_q;
   assign bus.incr = incr_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
endmodule
